// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the next-PC sequencer and the PC register / instruction memory.
interface pc_sequencer_if;
   logic [31:0] current_count;
   logic [31:0] new_count;
   logic        imem_req;
   logic        imem_ack;

   // Sequencer side: computes the next PC and requests fetches.
   modport master (
      input  current_count,
      input  imem_ack,
      output new_count,
      output imem_req
   );

   // PC register / memory side.
   modport slave (
      output current_count,
      output imem_ack,
      input  new_count,
      input  imem_req
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequences fetch over a req/ack handshake, applies hazard stalls,
// branch/jump redirects with one delay slot, and exception redirect with EPC capture.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
   input  logic                  clk,
   input  logic                  reset,
   pc_sequencer_if.master        bus,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [31:0]           branch_target,
   input  logic                  jump,
   input  logic [31:0]           jump_target,
   input  logic                  exception,
   output logic                  instr_valid,
   output logic [31:0]           issue_pc,
   output logic                  in_delay_slot,
   output logic [31:0]           epc
);

   typedef enum logic [1:0] {StStart, StFetch, StExc} state_t;

   state_t      state_q;
   logic        pending_q;
   logic [31:0] pend_target_q;
   logic [31:0] epc_q;
   logic [31:0] last_pc_q;

   logic        fetch;
   logic        exc_fire;
   logic        would_issue;
   logic        redirect;
   logic [31:0] redir_target;

   // Handshake, issue and redirect decode; new_count is forced to the reset vector under reset.
   always_comb begin
      fetch        = (state_q == StFetch);
      // Exceptions are ignored while already in the exception state.
      exc_fire     = exception & (state_q != StExc);
      // Issue ignoring the exception; EPC uses it to decide which PC was aborted.
      would_issue  = fetch & ~stall & bus.imem_ack;
      bus.imem_req = fetch & ~stall & ~exc_fire;
      instr_valid  = would_issue & ~exc_fire;
      // A second redirect while one is pending (branch in delay slot) is dropped.
      redirect     = (jump | branch_taken) & (state_q != StExc) & ~pending_q & ~exc_fire;
      redir_target = jump ? jump_target : branch_target;
      redir_target[1:0] = 2'b00;

      if (!reset) begin
         bus.new_count = RESET_VECTOR;
      end else if (exc_fire) begin
         bus.new_count = EXC_VECTOR;
      end else if (instr_valid) begin
         bus.new_count = pending_q ? pend_target_q : bus.current_count + 32'd4;
      end else begin
         bus.new_count = bus.current_count;
      end
   end

   assign issue_pc      = bus.current_count;
   assign in_delay_slot = pending_q;
   assign epc           = epc_q;

   // Sequencer FSM plus redirect, EPC and last-issued-PC registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StStart;
         pending_q     <= 1'b0;
         pend_target_q <= 32'h0;
         epc_q         <= 32'h0;
         last_pc_q     <= 32'h0;
      end else if (exc_fire) begin
         state_q   <= StExc;
         epc_q     <= would_issue ? bus.current_count : last_pc_q;
         pending_q <= 1'b0;
      end else begin
         case (state_q)
            StStart: state_q <= StFetch;
            StFetch: state_q <= StFetch;
            StExc:   state_q <= StFetch;
            default: state_q <= StStart;
         endcase
         if (instr_valid) begin
            last_pc_q <= bus.current_count;
         end
         // The issue that consumes the pending target ends the delay slot.
         if (pending_q) begin
            if (instr_valid) begin
               pending_q <= 1'b0;
            end
         end else if (redirect) begin
            pending_q     <= 1'b1;
            pend_target_q <= redir_target;
         end
      end
   end

endmodule
